// File: rtl/irq_pending_arbiter.sv
// Pending-interrupt register with a strict-priority, non-preemptive offer/accept handshake.
// Optional lost-request counter enabled by defining IRQ_ARB_LOST_CNT_EN.
module irq_pending_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [3:0]  code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [15:0] pending
`ifdef IRQ_ARB_LOST_CNT_EN
    ,
    output logic [7:0]  lost_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_code;
    logic [3:0]  w_nextCode;
    logic [15:0] r_pending;
    logic [15:0] w_clr;
    logic [3:0]  w_highIdx;
    logic        w_valid;

    // Lowest-to-highest scan so the last hit is the highest set index.
    always_comb begin
        w_highIdx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_pending[i]) begin
                w_highIdx = 4'(i);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCode  = r_code;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_nextState = OFFER;
                    w_nextCode  = w_highIdx;
                end
            end
            OFFER: begin
                w_valid = 1'b1;
                if (code_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_clr = (w_valid && code_ready) ? (16'h0001 << r_code) : 16'h0000;

    // A new request on the bit being cleared wins because the OR is applied last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_code    <= 4'd0;
            r_pending <= 16'h0000;
        end else begin
            r_state   <= w_nextState;
            r_code    <= w_nextCode;
            r_pending <= (r_pending & ~w_clr) | req;
        end
    end

    assign code       = r_code;
    assign code_valid = w_valid;
    assign pending    = r_pending;

`ifdef IRQ_ARB_LOST_CNT_EN
    logic [7:0]  r_lost;
    logic [15:0] w_lostBits;
    logic [4:0]  w_lostInc;
    logic [8:0]  w_lostSum;

    assign w_lostBits = req & r_pending & ~w_clr;

    always_comb begin
        w_lostInc = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_lostInc = w_lostInc + {4'd0, w_lostBits[i]};
        end
    end

    assign w_lostSum = {1'b0, r_lost} + {4'd0, w_lostInc};

    // Saturate rather than wrap so a stuck source cannot hide its history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lost <= 8'd0;
        end else begin
            r_lost <= w_lostSum[8] ? 8'hFF : w_lostSum[7:0];
        end
    end

    assign lost_cnt = r_lost;
`endif

endmodule

// File: doc/irq_pending_arbiter.md
IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port req, input, 16 bits: per-line request events, sampled every rising edge; bit i means source i.
REQ-004 The module SHALL have port code, output, 4 bits: index of the offered source.
REQ-005 The module SHALL have port code_valid, output, 1 bit: an offer is present on code.
REQ-006 The module SHALL have port code_ready, input, 1 bit: the consumer accepts the offer.
REQ-007 The module SHALL have port pending, output, 16 bits: the current pending register, pending_q.
REQ-008 The module SHALL have port lost_cnt, output, 8 bits, present only when the Configuration macro is defined: count of lost requests.

Function
REQ-009 The module SHALL compute the pending update at each edge as pending_q <= (pending_q & ~clr) | req.
  - clr is the one-hot of code when code_valid && code_ready, else 0.
  - A set on the same cycle as a clear of the same bit wins, so the bit stays pending.
REQ-010 The module SHALL treat req held high for N cycles as N events; set is level-sampled each edge.
REQ-011 The module SHALL implement a 2-state FSM with states IDLE and OFFER.
REQ-012 In IDLE, the module SHALL drive code_valid=0.
  - If pending_q != 0 at the edge, it SHALL load code_q = highest set index of pending_q (bit 15 highest priority, bit 0 lowest) and go to OFFER.
  - Otherwise it SHALL stay in IDLE.
REQ-013 In OFFER, the module SHALL drive code_valid=1 and code=code_q.
  - code SHALL hold stable until the handshake, with no preemption by newly pending higher-priority sources.
REQ-014 When code_valid && code_ready at an edge, the module SHALL clear pending bit code_q per REQ-009 and return to IDLE.
REQ-015 The module SHALL ignore code_ready while in IDLE.
REQ-016 Latency: for a req pulse sampled at edge k, pending_q[i] SHALL be 1 after edge k, and code_valid SHALL be 1 after edge k+1 when the FSM is in IDLE at edge k+1.
REQ-017 Throughput SHALL be at most one accepted code per 2 cycles, since one IDLE cycle follows every handshake.
REQ-018 When pending_q == 0, the module SHALL hold code at its last value, code_valid SHALL stay 0, and the FSM SHALL stay in IDLE.
REQ-019 A single-bit pending set SHALL be served in strict priority order after each handshake; no request SHALL ever be dropped from pending_q except by its own handshake.

Reset
REQ-020 While rst=1, the module SHALL asynchronously force:
  - pending_q=0, code_q=0 (code=0), code_valid=0;
  - FSM=IDLE;
  - lost_cnt=0 when present.
REQ-021 A reset asserted during OFFER SHALL drop the outstanding offer; after release, req is sampled from the next rising edge.

Configuration
REQ-022 Macro IRQ_ARB_LOST_CNT_EN SHALL control the lost-request counter.
  - Defined: the lost_cnt port and an 8-bit counter exist. For each edge, the counter adds the number of bits i with req[i]=1 and pending_q[i]=1 and not cleared that cycle. It saturates at 255 and never wraps.
  - Undefined: no port, no counter logic; all other behaviour is identical.

Verification
REQ-023 A bench SHALL cover a single pulse: reset, then req=16'h0008 for one cycle -> pending=16'h0008 next cycle; code=4'd3 with code_valid=1 one cycle later; after ready, pending=0 and code_valid=0.
REQ-024 A bench SHALL cover priority order: req=16'h8421 for one cycle, ready held 1 -> codes 15, 10, 5, 0 offered, each separated by one IDLE cycle; pending empties after the 4th handshake.
REQ-025 A bench SHALL cover no preemption: offer code=2 with ready=0, then pulse req[14] -> code stays 2 until ready; next offer is 14.
REQ-026 A bench SHALL cover set-wins: in the same cycle as the handshake for code=7, assert req[7] -> pending[7] remains 1 and code 7 is offered again.
REQ-027 A bench SHALL cover reset mid-offer: code_valid=1, code=9, pending=16'h0300; assert rst asynchronously between edges -> all outputs 0 immediately; no offer after release until a new req arrives.
REQ-028 A bench SHALL cover the lost counter (IRQ_ARB_LOST_CNT_EN defined): hold req[1]=1 for 300 cycles with ready=0 -> lost_cnt saturates at 255; undefined build -> no lost_cnt port.
